// File: rtl/spe_accumulator.sv
// rtl/spe_accumulator.sv - sum-PE stage: accumulates per-slot partial sums, thresholds against residual, emits spikes
module spe_accumulator #(
    parameter int SPE_ID      = 0,
    parameter int FILTER_SIZE = 5,
    parameter int NUM_SLOTS   = 89,
    parameter int THRESHOLD   = 64,
    parameter int OMEM_ID     = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_opcode,
    input  logic [24:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_dest,
    output logic [3:0]  out_opcode,
    output logic [24:0] out_data,
    output logic        err
);

    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [2:0]         FS3   = 3'(FILTER_SIZE);
    localparam logic [SW-1:0]      LAST  = SW'(NUM_SLOTS - 1);
    localparam logic signed [16:0] THR17 = 17'(THRESHOLD);
    localparam logic signed [17:0] THR18 = 18'(THRESHOLD);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACCUM = 3'd1,
        FIRE  = 3'd2,
        SEND  = 3'd3,
        CLEAR = 3'd4
    } state_t;

    state_t state, next_state;

    logic [2:0]         cnt [NUM_SLOTS];
    logic signed [16:0] acc [NUM_SLOTS];
    logic signed [16:0] res [NUM_SLOTS];

    logic [8:0]         lat_slot;
    logic [13:0]        lat_psum;
    logic [SW-1:0]      clr_idx;
    logic               ts;

    logic [SW-1:0]      slot_idx;
    logic               slot_ok;
    logic [2:0]         cnt_new;
    logic signed [16:0] psum_ext;
    logic signed [17:0] mem_wide;
    logic signed [16:0] mem;
    logic signed [17:0] sub_wide;
    logic signed [16:0] new_res;
    logic               spike;
    logic               any_cnt;
    logic               unused_bits;

    assign unused_bits = ^in_data[15:14];
    assign out_dest    = 4'(OMEM_ID);
    assign out_opcode  = 4'(SPE_ID);

    function automatic logic signed [16:0] sat17(input logic signed [17:0] v);
        if (v > 18'sd65535)
            return 17'sd65535;
        else if (v < -18'sd65536)
            return -17'sd65536;
        else
            return v[16:0];
    endfunction

    assign slot_idx = lat_slot[SW-1:0];
    assign slot_ok  = (int'(lat_slot) < NUM_SLOTS);
    assign cnt_new  = cnt[slot_idx] + 3'd1;
    assign psum_ext = {{3{lat_psum[13]}}, lat_psum};

    // Membrane update for the slot being fired; both sums widened by one bit before clamping
    always_comb begin
        mem_wide = {res[slot_idx][16], res[slot_idx]} + {acc[slot_idx][16], acc[slot_idx]};
        mem      = sat17(mem_wide);
        spike    = (mem >= THR17);
        sub_wide = {mem[16], mem} - THR18;
        new_res  = spike ? sat17(sub_wide) : mem;
    end

    always_comb begin
        any_cnt = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++)
            any_cnt = any_cnt | (cnt[i] != 3'd0);
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    if (in_opcode == 4'd0)
                        next_state = ACCUM;
                    else if (in_opcode == 4'd15)
                        next_state = CLEAR;
                end
            end
            ACCUM: begin
                if (slot_ok && cnt_new == FS3)
                    next_state = FIRE;
                else
                    next_state = IDLE;
            end
            FIRE:  next_state = SEND;
            SEND:  if (out_ready) next_state = IDLE;
            CLEAR: if (clr_idx == LAST) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // in_ready is registered so it stays low while reset is asserted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            in_ready <= 1'b0;
        end else begin
            state    <= next_state;
            in_ready <= (next_state == IDLE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_slot  <= '0;
            lat_psum  <= '0;
            clr_idx   <= '0;
            ts        <= 1'b0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                cnt[i] <= '0;
                acc[i] <= '0;
                res[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    clr_idx <= '0;
                    if (in_valid && in_ready) begin
                        lat_slot <= in_data[24:16];
                        lat_psum <= in_data[13:0];
                        if (in_opcode != 4'd0 && in_opcode != 4'd15)
                            err <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (!slot_ok) begin
                        err <= 1'b1;
                    end else begin
                        acc[slot_idx] <= acc[slot_idx] + psum_ext;
                        cnt[slot_idx] <= cnt_new;
                    end
                end
                FIRE: begin
                    res[slot_idx] <= new_res;
                    acc[slot_idx] <= '0;
                    cnt[slot_idx] <= '0;
                    out_data      <= {lat_slot, 14'd0, ts, spike};
                    out_valid     <= 1'b1;
                end
                SEND: begin
                    if (out_ready)
                        out_valid <= 1'b0;
                end
                CLEAR: begin
                    // Incomplete pixels are only detectable before the sweep starts zeroing counts
                    if (clr_idx == '0 && any_cnt)
                        err <= 1'b1;
                    cnt[clr_idx] <= '0;
                    acc[clr_idx] <= '0;
                    clr_idx      <= clr_idx + 1'b1;
                    if (clr_idx == LAST)
                        ts <= ~ts;
                end
                default: ;
            endcase
        end
    end

endmodule
